// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
// Field indices describe the {remainder, quotient} result word at the native width.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} div_state_e;

  localparam int DIV_W            = 32;
  localparam int REM_HI           = 63;
  localparam int REM_LO           = 32;
  localparam int QUO_HI           = 31;
  localparam int QUO_LO           = 0;
  localparam int DRAIN_CYCLES_DEF = 2;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake between the issue controller (master) and the iterative divider (slave).
interface div_issue_ctrl_if import div_pkg::*; #(parameter int DATA_W = DIV_W);

  logic                  start;
  logic                  annul;
  logic                  is_signed;
  logic [DATA_W-1:0]     op1;
  logic [DATA_W-1:0]     op2;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;

  modport master (output start, annul, is_signed, op1, op2, input result, ready);
  modport slave  (input start, annul, is_signed, op1, op2, output result, ready);

endinterface

// File: rtl/div_result_cache.sv
// One-entry result cache keyed on {signed, op1, op2}; only built with DIV_RESULT_CACHE_EN.
module div_result_cache import div_pkg::*; #(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_signed,
  input  logic [DATA_W-1:0] wr_op1,
  input  logic [DATA_W-1:0] wr_op2,
  input  logic [DATA_W-1:0] wr_hi,
  input  logic [DATA_W-1:0] wr_lo,
  input  logic              rd_signed,
  input  logic [DATA_W-1:0] rd_op1,
  input  logic [DATA_W-1:0] rd_op2,
  output logic              hit,
  output logic [DATA_W-1:0] rd_hi,
  output logic [DATA_W-1:0] rd_lo
);

  logic              valid_q;
  logic              signed_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      signed_q <= wr_signed;
      op1_q    <= wr_op1;
      op2_q    <= wr_op2;
      hi_q     <= wr_hi;
      lo_q     <= wr_lo;
    end
  end

  assign hit   = valid_q && (signed_q == rd_signed) && (op1_q == rd_op1) && (op2_q == rd_op2);
  assign rd_hi = hi_q;
  assign rd_lo = lo_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: latches operands, stalls until ready,
// captures HI/LO, releases the divider and drains it after a flush. Optional: DIV_RESULT_CACHE_EN.
module div_issue_ctrl import div_pkg::*; #(
  parameter int DATA_W       = DIV_W,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_valid_i,
  input  logic              ex_div_signed_i,
  input  logic [DATA_W-1:0] ex_op1_i,
  input  logic [DATA_W-1:0] ex_op2_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  div_issue_ctrl_if.master  div
);

  localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  div_state_e        state_q, state_d;
  logic              signed_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              issue, capture, load_hit, cache_hit;
  logic              stall_c, start_c, annul_c, valid_c;
  logic [DATA_W-1:0] rem_w, quo_w, cache_hi, cache_lo;

  if (DATA_W == DIV_W) begin : g_pkg_fields
    assign rem_w = div.result[REM_HI:REM_LO];
    assign quo_w = div.result[QUO_HI:QUO_LO];
  end else begin : g_param_fields
    assign rem_w = div.result[2*DATA_W-1:DATA_W];
    assign quo_w = div.result[DATA_W-1:0];
  end

  assign issue    = ex_div_valid_i && !flush_i;
  assign capture  = (state_q == BUSY) && div.ready && !flush_i;
  assign load_hit = (state_q == IDLE) && issue && cache_hit;

`ifdef DIV_RESULT_CACHE_EN
  div_result_cache #(.DATA_W(DATA_W)) u_cache (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (capture),
    .wr_signed (signed_q),
    .wr_op1    (op1_q),
    .wr_op2    (op2_q),
    .wr_hi     (rem_w),
    .wr_lo     (quo_w),
    .rd_signed (ex_div_signed_i),
    .rd_op1    (ex_op1_i),
    .rd_op2    (ex_op2_i),
    .hit       (cache_hit),
    .rd_hi     (cache_hi),
    .rd_lo     (cache_lo)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_hi  = '0;
  assign cache_lo  = '0;
`endif

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    start_c = 1'b0;
    annul_c = 1'b0;
    valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = issue;
        if (issue) state_d = cache_hit ? DONE : BUSY;
      end
      BUSY: begin
        start_c = 1'b1;
        stall_c = 1'b1;
        // flush has priority over a ready arriving in the same cycle
        if (flush_i) begin
          annul_c = 1'b1;
          state_d = DRAIN;
        end else if (div.ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid_c = 1'b1;
        if (flush_i || !ex_stall_i) state_d = IDLE;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && issue) begin
        signed_q <= ex_div_signed_i;
        op1_q    <= ex_op1_i;
        op2_q    <= ex_op2_i;
      end
      if (capture) begin
        hi_q <= rem_w;
        lo_q <= quo_w;
      end else if (load_hit) begin
        hi_q <= cache_hi;
        lo_q <= cache_lo;
      end
      // counter is loaded on the abort edge so DRAIN lasts exactly DRAIN_CYCLES cycles
      if (state_q == BUSY && flush_i) cnt_q <= DRAIN_LOAD;
      else if (state_q == DRAIN && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign stall_o        = stall_c;
  assign result_valid_o = valid_c;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign div.start      = start_c;
  assign div.annul      = annul_c;
  assign div.is_signed  = signed_q;
  assign div.op1        = op1_q;
  assign div.op2        = op2_q;

endmodule
